// File: rtl/apb_master_bridge_if.sv
// Bundle of the command, response and APB3 signals for apb_master_bridge.
// The master modport is the bridge's view; slave is the environment's view.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    logic                  busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata,
        input  busy
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: valid/ready command in, APB3 transfer out,
// one valid/ready response per command (including slave errors and timeouts).
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    apb_master_bridge_if.master bus_io
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  timed_out;

    assign accept    = (state_q == StIdle) && bus_io.cmd_valid && cmd_ready_q;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutVal);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    paddr_d  = bus_io.cmd_addr;
                    pwrite_d = bus_io.cmd_write;
                    pwdata_d = bus_io.cmd_write ? bus_io.cmd_wdata : '0;
                    cnt_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                // pready wins over a timeout falling on the same cycle
                if (bus_io.pready) begin
                    rsp_rdata_d   = (pwrite_q || bus_io.pslverr) ? '0 : bus_io.prdata;
                    rsp_err_d     = bus_io.pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (timed_out) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered copies decoded from the next state.
    always_comb begin
        cmd_ready_d = (state_d == StIdle);
        psel_d      = (state_d == StSetup) || (state_d == StAccess);
        penable_d   = (state_d == StAccess);
        rsp_valid_d = (state_d == StResp);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus_io.cmd_ready   = cmd_ready_q;
    assign bus_io.rsp_valid   = rsp_valid_q;
    assign bus_io.rsp_rdata   = rsp_rdata_q;
    assign bus_io.rsp_err     = rsp_err_q;
    assign bus_io.rsp_timeout = rsp_timeout_q;
    assign bus_io.paddr       = paddr_q;
    assign bus_io.psel        = psel_q;
    assign bus_io.penable     = penable_q;
    assign bus_io.pwrite      = pwrite_q;
    assign bus_io.pwdata      = pwdata_q;
    assign bus_io.busy        = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table plus hand-written
// sequences, with a response scoreboard fed at command issue time.
module tb_apb_master_bridge;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic clk;
    logic rst_n;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          wait_n;
        bit          stuck;
        bit          slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    vec_t vecs[8];
    rsp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Slave model controls
    int          sl_wait   = 0;
    bit          sl_stuck  = 1'b0;
    bit          sl_err    = 1'b0;
    bit          sl_pulse  = 1'b0;
    logic [31:0] sl_rdata  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // APB slave: pready is driven on the falling edge for the next rising edge
    initial begin : slave
        int acc;
        acc = 0;
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.psel && bus.penable) begin
                bus.pready = sl_pulse || (!sl_stuck && (acc == sl_wait));
                acc++;
            end else begin
                bus.pready = sl_pulse;
                acc = 0;
            end
            bus.prdata  = sl_rdata;
            bus.pslverr = sl_err;
        end
    end

    // Response monitor: pops the scoreboard on each handshake, checks hold stability
    initial begin : monitor
        bit   hold;
        rsp_t prev;
        rsp_t exp;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                    chk("rsp_hold_rdata", bus.rsp_rdata, prev.rdata);
                    chk("rsp_hold_err", {31'd0, bus.rsp_err}, {31'd0, prev.err});
                    chk("rsp_hold_timeout", {31'd0, bus.rsp_timeout}, {31'd0, prev.to});
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got response rdata=0x%0h err=%0b, expected none",
                                 bus.rsp_rdata, bus.rsp_err);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, exp.rdata);
                        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp.err});
                        chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, exp.to});
                    end
                end
                hold = bus.rsp_valid && !bus.rsp_ready;
                prev = '{bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
            end
        end
    end

    task automatic wait_cmd_ready(output bit ok);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = bus.cmd_ready;
        chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    // Issue one command and follow it through SETUP/ACCESS to rsp_valid
    task automatic xfer(input vec_t v);
        bit          ok;
        bit          done;
        int          lat;
        logic [31:0] exp_pwdata;
        sl_wait  = v.wait_n;
        sl_stuck = v.stuck;
        sl_err   = v.slverr;
        sl_rdata = v.prdata;
        exp_pwdata = v.wr ? v.wdata : 32'd0;
        wait_cmd_ready(ok);
        if (!ok) return;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            #1;
            lat++;
            if (bus.rsp_valid) begin
                done = 1'b1;
                chk("resp_psel", {31'd0, bus.psel}, 32'd0);
            end else begin
                chk("apb_psel", {31'd0, bus.psel}, 32'd1);
                chk("apb_penable", {31'd0, bus.penable}, (lat == 1) ? 32'd0 : 32'd1);
                chk("apb_paddr", {24'd0, bus.paddr}, {24'd0, v.addr});
                chk("apb_pwrite", {31'd0, bus.pwrite}, {31'd0, v.wr});
                chk("apb_pwdata", bus.pwdata, exp_pwdata);
                chk("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
                chk("busy", {31'd0, bus.busy}, 32'd1);
            end
        end
        chk("latency", lat - 1, v.exp_lat);
    endtask

    initial begin : main
        bit ok;
        int k;
        vec_t fresh;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;

        //            wr    addr   wdata          wait st  err prdata         exp_rdata      e  t  lat
        vecs[0] = '{1'b1, 8'h04, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b0, 8'h08, 32'h1111_1111, 3, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b0, 8'h0C, 32'h2222_2222, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 2};
        vecs[3] = '{1'b1, 8'h10, 32'h3C3C_C3C3, 1, 1'b0, 1'b1, 32'h7777_7777, 32'h0000_0000, 1'b1, 1'b0, 3};
        vecs[4] = '{1'b0, 8'h14, 32'h0,         4, 1'b0, 1'b0, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 1'b0, 6};
        vecs[5] = '{1'b0, 8'h18, 32'h0,         0, 1'b1, 1'b0, 32'h9999_9999, 32'h0000_0000, 1'b1, 1'b1, 6};
        vecs[6] = '{1'b1, 8'hFC, 32'hFFFF_FFFF, 2, 1'b0, 1'b0, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b0, 4};
        vecs[7] = '{1'b0, 8'h00, 32'h0,         0, 1'b0, 1'b0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 2};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        chk("rst_paddr", {24'd0, bus.paddr}, 32'd0);
        chk("rst_psel", {31'd0, bus.psel}, 32'd0);
        chk("rst_penable", {31'd0, bus.penable}, 32'd0);
        chk("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
        chk("rst_pwdata", bus.pwdata, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("ready_after_first_edge", {31'd0, bus.cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i]);
            if (vecs[i].stuck) begin
                // late pready after a timeout must not produce a second response
                sl_pulse = 1'b1;
                repeat (2) @(negedge clk);
                #1;
                sl_pulse = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    chk("late_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                    chk("late_no_psel", {31'd0, bus.psel}, 32'd0);
                    @(negedge clk);
                    #1;
                end
            end
        end

        // Backpressure with a second command held on the command port
        sl_wait  = 0;
        sl_stuck = 1'b0;
        sl_err   = 1'b0;
        sl_rdata = 32'h5A5A_1234;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        wait_cmd_ready(ok);
        exp_q.push_back('{32'h5A5A_1234, 1'b0, 1'b0});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h20;
        bus.cmd_wdata = 32'h0;
        @(negedge clk);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h24;
        bus.cmd_wdata = 32'h0BAD_F00D;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!bus.rsp_valid && k < 20);
        chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        sl_rdata = 32'hDEAD_BEEF;
        for (int j = 0; j < 5; j++) begin
            chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("bp_rdata", bus.rsp_rdata, 32'h5A5A_1234);
            chk("bp_psel", {31'd0, bus.psel}, 32'd0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("b2b_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("b2b_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("b2b_idle_psel", {31'd0, bus.psel}, 32'd0);
        @(negedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("b2b_setup_psel", {31'd0, bus.psel}, 32'd1);
        chk("b2b_setup_penable", {31'd0, bus.penable}, 32'd0);
        chk("b2b_setup_paddr", {24'd0, bus.paddr}, 32'h24);
        chk("b2b_setup_pwdata", bus.pwdata, 32'h0BAD_F00D);
        chk("b2b_setup_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("b2b_drained", exp_q.size(), 32'd0);

        // Reset in the middle of ACCESS drops the transfer
        sl_stuck = 1'b1;
        wait_cmd_ready(ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h30;
        k = 0;
        do begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            #1;
            k++;
        end while (!(bus.psel && bus.penable) && k < 10);
        chk("rst_mid_in_access", {31'd0, bus.penable}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", {31'd0, bus.psel}, 32'd0);
        chk("rst_mid_penable", {31'd0, bus.penable}, 32'd0);
        chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_paddr", {24'd0, bus.paddr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        sl_stuck = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk("rst_mid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end

        fresh = '{1'b1, 8'h40, 32'h600D_CAFE, 1, 1'b0, 1'b0, 32'h1357_9BDF, 32'h0, 1'b0, 1'b0, 3};
        xfer(fresh);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that turns single-beat commands from a valid/ready command port into APB3 transfers toward the register-file slaves, and returns read data and status on a valid/ready response port. It sits between the firmware/DMA command fabric and the peripheral APB segment. One transfer is outstanding at a time. Every transfer completes with exactly one response, including those ended by slave error or timeout.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of cmd_addr and paddr
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before forced termination; 0 disables the timeout

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; everything is rising-edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts
- rsp_err  out  1  pslverr sampled high, or timeout
- rsp_timeout  out  1  transfer ended by timeout
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready:
    - latch cmd_addr into paddr and cmd_write into pwrite;
    - pwdata = cmd_wdata for writes, 0 for reads;
    - go to SETUP.
- **SETUP**
  - psel = 1, penable = 0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - psel = 1, penable = 1.
  - Each cycle with pready = 0 increments the wait counter.
  - **Completion:** on a cycle with pready = 1:
    - capture rsp_rdata = (pwrite || pslverr) ? 0 : prdata;
    - rsp_err = pslverr, rsp_timeout = 0;
    - go to RESP.
  - **Timeout:** if TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES while pready = 0:
    - rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1;
    - go to RESP.
  - A late pready after timeout is ignored.
- **RESP**
  - psel = 0, penable = 0, rsp_valid = 1.
  - rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_valid && rsp_ready, then go to IDLE.
- **APB output stability**
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
  - They keep their last value in RESP and IDLE.
- **Wait counter**
  - Width is clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Cleared on entry to SETUP.
  - Saturates; it never wraps.
- **Command port:** cmd_ready = 0 in SETUP, ACCESS and RESP; commands presented there are not consumed.
- **Reset values:** cmd_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_timeout 0, paddr 0, psel 0, penable 0, pwrite 0, pwdata 0, busy 0; FSM = IDLE.
- **First cycle after reset:** cmd_ready rises at the first clock edge after rst_n deasserts.
- **Reset mid-operation:** all outputs return to reset values asynchronously. The in-flight transfer is dropped and no response is produced.

## Timing
- Command accepted at edge T:
  - SETUP visible in T..T+1;
  - ACCESS from T+1.
- Zero-wait slave:
  - completion sampled at edge T+2;
  - rsp_valid high from T+2.
- N wait states: rsp_valid rises at T+2+N.
- Timeout: rsp_valid rises at T+2+TIMEOUT_CYCLES.
- rsp_ready high in the first RESP cycle: back in IDLE one edge later; the next command is accepted one edge after that.
- Minimum command-to-command spacing is 4 cycles with a zero-wait slave.
- pslverr is sampled only in the cycle where pready = 1 during ACCESS.

## Test plan
- **Zero-wait write:** cmd write addr 0x04 data 0xA5A5_0001, pready tied 1 -> psel for 2 cycles, penable in the 2nd only, pwdata = 0xA5A5_0001; rsp_valid 1 cycle later with rdata 0, err 0.
- **Read with wait states:** read addr 0x08, slave holds pready low for 3 ACCESS cycles, then prdata = 0x1234_5678 -> ACCESS lasts 4 cycles with paddr stable; rsp_rdata = 0x1234_5678, err 0, timeout 0.
- **Slave error:** read with pslverr = 1 on the pready cycle, prdata = 0xFFFF_FFFF -> rsp_err 1, rsp_rdata 0, rsp_timeout 0.
- **Timeout:** TIMEOUT_CYCLES = 4, pready stuck low -> psel drops after 4 wait cycles; rsp_err 1, rsp_timeout 1. pready pulsed afterwards -> no second response.
- **Response backpressure and back-to-back commands:** hold rsp_ready low for 5 cycles with cmd_valid held high -> cmd_ready stays 0 and the rsp fields stay stable; after the handshake, the second command is accepted with the spacing above.
- **Reset mid-ACCESS:** assert rst_n low during ACCESS -> psel, penable and rsp_valid go 0 immediately with no response. After release, a fresh write completes normally.
